// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: LdStCtrl codes,
// arbiter states, byte enables and lane helpers.
package mem_defs;

  localparam logic [2:0] LDST_LB  = 3'b000;
  localparam logic [2:0] LDST_LH  = 3'b001;
  localparam logic [2:0] LDST_LW  = 3'b010;
  localparam logic [2:0] LDST_LBU = 3'b011;
  localparam logic [2:0] LDST_LHU = 3'b100;
  localparam logic [2:0] LDST_SB  = 3'b101;
  localparam logic [2:0] LDST_SH  = 3'b110;
  localparam logic [2:0] LDST_SW  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } arb_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b1000;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;

  function automatic logic is_store(
    input logic [2:0] ldst
  );
    return ldst inside {LDST_SB, LDST_SH, LDST_SW};
  endfunction

  function automatic logic misaligned(
    input logic [2:0] ldst,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (ldst == LDST_LH),
      (ldst == LDST_LHU),
      (ldst == LDST_SH): bad = off[0];
      (ldst == LDST_LW),
      (ldst == LDST_SW): bad = (off != 2'b00);
      default:           bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(
    input logic [2:0] ldst,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = BE_ALL;
    unique case (1'b1)
      (ldst == LDST_SB): be = BE_B0 >> off;
      (ldst == LDST_SH): be = off[1] ? BE_LO : BE_HI;
      default:           be = BE_ALL;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  ldst,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (1'b1)
      (ldst == LDST_SB): d = {4{wd[7:0]}};
      (ldst == LDST_SH): d = {2{wd[15:0]}};
      default:           d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bundle between the arbiter
// (master) and the memory (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_load_align.sv
// Load return path: big-endian lane select
// followed by sign or zero extension.
import mem_defs::*;

module load_align (
  input  logic [2:0]  ldst,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // offset 0 is the most significant lane
  always_comb begin
    bsel = 8'(word >> {~offset, 3'b000});
    hsel = offset[1] ? word[15:0] : word[31:16];
    result = word;
    unique case (1'b1)
      (ldst == LDST_LB):  result = {{24{bsel[7]}}, bsel};
      (ldst == LDST_LBU): result = {24'h0, bsel};
      (ldst == LDST_LH):  result = {{16{hsel[15]}}, hsel};
      (ldst == LDST_LHU): result = {16'h0, hsel};
      default:            result = word;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the unified memory port.
// Optional misalign trap: MEM_ALIGN_CHECK_EN.
import mem_defs::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [2:0]        dm_ldst,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  mem_port_arbiter_if.master mem
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(3);

  arb_state_t  state, state_n;
  logic [3:0]  starve_cnt, starve_n;
  logic [2:0]  ldst_q;
  logic [1:0]  off_q;
  logic        dm_win, if_win, dm_bad;
  logic        store, issue;
  logic [31:0] ld_res;

  load_align u_align (
    .ldst   (ldst_q),
    .offset (off_q),
    .word   (mem.mem_rdata),
    .result (ld_res)
  );

  // arbitration, issue and return; all quiet in reset
  always_comb begin
    state_n       = state;
    starve_n      = starve_cnt;
    dm_win        = 1'b0;
    if_win        = 1'b0;
    dm_bad        = 1'b0;
    issue         = 1'b0;
    store         = is_store(dm_ldst);
    if_gnt        = 1'b0;
    if_rvalid     = 1'b0;
    if_rdata      = 32'h0;
    dm_gnt        = 1'b0;
    dm_rvalid     = 1'b0;
    dm_rdata      = 32'h0;
    dm_err        = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = BE_NONE;
    mem.mem_wdata = 32'h0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          dm_win = dm_req &&
            !(if_req && starve_cnt == SMAX);
          if_win = !dm_win && if_req;
`ifdef MEM_ALIGN_CHECK_EN
          dm_bad = dm_win &&
            misaligned(dm_ldst, dm_addr[1:0]);
`else
          dm_bad = 1'b0;
`endif
          if (dm_win && !dm_bad) begin
            mem.mem_req  = 1'b1;
            mem.mem_we   = store;
            mem.mem_addr = dm_addr & AMASK;
            if (store) begin
              mem.mem_be =
                store_be(dm_ldst, dm_addr[1:0]);
              mem.mem_wdata =
                store_data(dm_ldst, dm_wdata);
            end else begin
              mem.mem_be = BE_ALL;
            end
          end else if (if_win) begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = if_addr & AMASK;
            mem.mem_be   = BE_ALL;
          end
          issue  = mem.mem_req && mem.mem_ready;
          if_gnt = if_win && issue;
          dm_gnt = dm_win && (issue || dm_bad);
          dm_err = dm_bad;
          if (if_gnt) begin
            starve_n = 4'h0;
            state_n  = RD_IF;
          end else if (dm_gnt) begin
            if (!if_req)
              starve_n = 4'h0;
            else if (starve_cnt != 4'hF)
              starve_n = starve_cnt + 4'h1;
            if (!store && !dm_bad)
              state_n = RD_DM;
          end else if (!if_req) begin
            starve_n = 4'h0;
          end
        end
        RD_IF: begin
          if (!if_req) starve_n = 4'h0;
          if (mem.mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem.mem_rdata;
            state_n   = IDLE;
          end
        end
        RD_DM: begin
          if (!if_req) starve_n = 4'h0;
          if (mem.mem_rvalid) begin
            dm_rvalid = 1'b1;
            dm_rdata  = ld_res;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // state, starvation count and load context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'h0;
      ldst_q     <= LDST_LB;
      off_q      <= 2'b00;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      if (dm_gnt && state_n == RD_DM) begin
        ldst_q <= dm_ldst;
        off_q  <= dm_addr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Follows MEM_ALIGN_CHECK_EN if defined.
import mem_defs::*;

module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [2:0]  dm_ldst;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  int          errors = 0;
  int          checks = 0;

  mem_port_arbiter_if #(.ADDR_W(32)) mem ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_ldst   (dm_ldst),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem       (mem)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(
    input string       tag,
    input logic [2:0]  ldst,
    input logic [31:0] addr,
    input logic [31:0] exp
  );
    dm_req  = 1'b1;
    dm_ldst = ldst;
    dm_addr = addr;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(dm_gnt), 32'd1);
    nxt();
    dm_req         = 1'b0;
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'h12F4_80FF;
    @(negedge clk);
    check({tag, "_rv"}, 32'(dm_rvalid), 32'd1);
    check(tag, dm_rdata, exp);
    nxt();
    mem.mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    if_req         = 1'b0;
    if_addr        = 32'h0;
    dm_req         = 1'b0;
    dm_addr        = 32'h0;
    dm_ldst        = LDST_LB;
    dm_wdata       = 32'h0;
    mem.mem_ready  = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata  = 32'h0;

    @(negedge clk);
    check("rst_req", 32'(mem.mem_req), 32'd0);
    check("rst_be", 32'(mem.mem_be), 32'd0);
    check("rst_ifg", 32'(if_gnt), 32'd0);
    check("rst_dmg", 32'(dm_gnt), 32'd0);
    check("rst_cnt", 32'(dut.starve_cnt), 32'd0);

    nxt();
    rst_n          = 1'b1;
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    check("stale_dm", 32'(dm_rvalid), 32'd0);
    check("stale_if", 32'(if_rvalid), 32'd0);

    nxt();
    mem.mem_rvalid = 1'b0;
    dm_req         = 1'b1;
    dm_addr        = 32'h100;
    dm_ldst        = LDST_LW;
    if_req         = 1'b1;
    if_addr        = 32'h40;
    mem.mem_ready  = 1'b1;
    @(negedge clk);
    check("ct_dmg", 32'(dm_gnt), 32'd1);
    check("ct_ifg", 32'(if_gnt), 32'd0);
    check("ct_addr", mem.mem_addr, 32'h100);
    check("ct_be", 32'(mem.mem_be), 32'hF);
    check("ct_we", 32'(mem.mem_we), 32'd0);
    nxt();
    dm_req = 1'b0;
    @(negedge clk);
    check("ct_wait_req", 32'(mem.mem_req), 32'd0);
    check("ct_wait_ifg", 32'(if_gnt), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ct_rv", 32'(dm_rvalid), 32'd1);
    check("ct_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("ct_rv_ifg", 32'(if_gnt), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b0;
    @(negedge clk);
    check("ct_ifg2", 32'(if_gnt), 32'd1);
    check("ct_ifaddr", mem.mem_addr, 32'h40);
    nxt();
    if_req = 1'b0;
    @(negedge clk);
    check("if_wait", 32'(mem.mem_req), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    check("if_rv", 32'(if_rvalid), 32'd1);
    check("if_rdata", if_rdata, 32'hCAFE_F00D);
    check("if_dmrv", 32'(dm_rvalid), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b0;

    do_load("lb2", LDST_LB, 32'h302, 32'hFFFF_FF80);
    do_load("lbu1", LDST_LBU, 32'h301, 32'h0000_00F4);
    do_load("lh2", LDST_LH, 32'h302, 32'hFFFF_80FF);
    do_load("lhu0", LDST_LHU, 32'h300, 32'h0000_12F4);
    do_load("lb3", LDST_LB, 32'h303, 32'hFFFF_FFFF);
    do_load("lw", LDST_LW, 32'h300, 32'h12F4_80FF);

    dm_req   = 1'b1;
    dm_ldst  = LDST_SB;
    dm_addr  = 32'h203;
    dm_wdata = 32'h5566_77AB;
    @(negedge clk);
    check("sb_gnt", 32'(dm_gnt), 32'd1);
    check("sb_we", 32'(mem.mem_we), 32'd1);
    check("sb_be", 32'(mem.mem_be), 32'h1);
    check("sb_wd", mem.mem_wdata, 32'hABAB_ABAB);
    check("sb_addr", mem.mem_addr, 32'h200);
    nxt();
    dm_ldst  = LDST_SH;
    dm_addr  = 32'h200;
    dm_wdata = 32'h9999_1234;
    @(negedge clk);
    check("sh_gnt", 32'(dm_gnt), 32'd1);
    check("sh_be", 32'(mem.mem_be), 32'hC);
    check("sh_wd", mem.mem_wdata, 32'h1234_1234);
    nxt();
    dm_addr = 32'h202;
    @(negedge clk);
    check("sh2_be", 32'(mem.mem_be), 32'h3);
    nxt();

    if_req   = 1'b1;
    if_addr  = 32'h80;
    dm_ldst  = LDST_SW;
    dm_addr  = 32'h400;
    dm_wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stv_dmg%0d", i),
            32'(dm_gnt), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("stv_ifg%0d", i),
            32'(if_gnt), (i == 4) ? 32'd1 : 32'd0);
      nxt();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    check("stv_cnt", 32'(dut.starve_cnt), 32'd0);
    check("stv_req", 32'(mem.mem_req), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    check("stv_rv", 32'(if_rvalid), 32'd1);
    nxt();
    mem.mem_rvalid = 1'b0;

    dm_req  = 1'b1;
    dm_ldst = LDST_LW;
    dm_addr = 32'h500;
    @(negedge clk);
    check("mr_gnt", 32'(dm_gnt), 32'd1);
    nxt();
    dm_req         = 1'b0;
    if_req         = 1'b1;
    rst_n          = 1'b0;
    mem.mem_rvalid = 1'b1;
    @(negedge clk);
    check("mr_req", 32'(mem.mem_req), 32'd0);
    check("mr_ifg", 32'(if_gnt), 32'd0);
    check("mr_rv", 32'(dm_rvalid), 32'd0);
    check("mr_be", 32'(mem.mem_be), 32'd0);
    nxt();
    rst_n         = 1'b1;
    if_req        = 1'b0;
    mem.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("mr_after", 32'(dm_rvalid), 32'd0);
    nxt();
    mem.mem_rvalid = 1'b0;

    dm_req   = 1'b1;
    dm_ldst  = LDST_SW;
    dm_addr  = 32'h102;
    dm_wdata = 32'h0102_0304;
    @(negedge clk);
    check("mis_gnt", 32'(dm_gnt), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_err", 32'(dm_err), 32'd1);
    check("mis_req", 32'(mem.mem_req), 32'd0);
`else
    check("mis_err", 32'(dm_err), 32'd0);
    check("mis_addr", mem.mem_addr, 32'h100);
    check("mis_be", 32'(mem.mem_be), 32'hF);
`endif
    nxt();
    dm_req = 1'b0;
    @(negedge clk);
    check("mis_gnt2", 32'(dm_gnt), 32'd0);
    check("mis_err2", 32'(dm_err), 32'd0);
    check("mis_idle", 32'(mem.mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between instruction fetch and the data load/store path of the MIPS pipeline. Fixed data-over-fetch priority with a starvation bound, one outstanding transaction at a time. Translates the control unit's 3-bit LdStCtrl code into byte enables and store-lane replication on the way out. On the way back it does load alignment and sign/zero extension.

## Interface
- ADDR_W, 32, byte address width
- STARVE_MAX, 4, consecutive data wins tolerated while fetch waits (1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address (word aligned)
- if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request, held until dm_gnt
- dm_addr  in  ADDR_W  data byte address
- dm_ldst  in  3  LdStCtrl: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- dm_wdata  in  32  store data, right-justified
- dm_gnt  out  1  one-cycle pulse: data request accepted (store complete)
- dm_rvalid  out  1  one-cycle pulse: dm_rdata valid
- dm_rdata  out  32  aligned, extended load result
- dm_err  out  1  misaligned request, valid with dm_gnt (macro only)
- mem_req  out  1  memory request
- mem_we  out  1  write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables, bit 3 = bits [31:24]
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid, at least one cycle after acceptance
- mem_rdata  in  32  read word

## Operation
- States: IDLE, RD_IF, RD_DM. Reset → IDLE, starve_cnt = 0, every output 0.
- IDLE, arbitration is combinational:
  - Winner = data if dm_req && !(if_req && starve_cnt == STARVE_MAX).
  - Otherwise winner = fetch if if_req.
  - mem_req and the mem_* fields are driven from the winner in the same cycle.
- Issue completes when mem_req && mem_ready:
  - Pulse the winner's gnt.
  - Fetch or load: latch ldst and addr[1:0], go to RD_IF or RD_DM.
  - Store: stay in IDLE.
- No mem_ready: hold the request. The winner may change next cycle if priority inputs change.
- RD_IF / RD_DM: mem_req = 0. On mem_rvalid, pulse the owner's rvalid with the data and return to IDLE. New issue happens the following cycle, never the same cycle.
- Starvation: starve_cnt +1 (saturating) on each data issue while if_req = 1. Cleared on fetch issue or whenever if_req = 0.
- Big-endian lanes, offset 0 = bits [31:24].
- Stores:
  - SB: mem_be = 4'b1000 >> addr[1:0], byte replicated ×4.
  - SH: mem_be = addr[1] ? 0011 : 1100, half replicated ×2.
  - SW: mem_be = 1111.
- Loads and fetches: mem_be = 1111, mem_we = 0.
- Load return:
  - Select the byte/half using the latched offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_rvalid in IDLE (stale, e.g. after reset) is ignored.
- Reset mid-transaction: outstanding access abandoned, no rvalid pulse is produced.

## Timing
- Issue latency: gnt in the same cycle as mem_ready, zero added cycles.
- Read result: owner rvalid in the same cycle as mem_rvalid (combinational path from mem_rdata through extend logic).
- State, starve_cnt and latched ldst/offset are registered. All other outputs are combinational from state and inputs.
- Minimum spacing: a load occupies at least 2 cycles. Back-to-back stores may issue on every cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned request: LH/LHU/SH with addr[0] = 1, LW/SW with addr[1:0] != 0.
  - A misaligned request that wins arbitration is not sent to memory (mem_req = 0).
  - dm_gnt and dm_err pulse together for one cycle, state stays IDLE. It still counts as a data win for starve_cnt.
- Not defined: dm_err tied 0, low address bits beyond the access size are ignored, the access is issued normally.

## Structure
- Shared header/package `mem_defs`:
  - LdStCtrl code constants (LDST_LB … LDST_SW).
  - Arbiter state encodings.
  - Byte-enable constants.
- The control unit and the datapath use the same LdStCtrl constants from `mem_defs`.
- One sub-module `load_align`: combinational (ldst, offset, word) → extended result.

## Test plan
- Load vs fetch contention:
  - Stimulus: dm_req LW @0x100 and if_req @0x40 both asserted, mem_ready = 1, rvalid returns 0xDEADBEEF two cycles later.
  - Response: dm_gnt first, dm_rdata = 0xDEADBEEF. Fetch issues the cycle after dm_rvalid.
- Starvation bound:
  - Stimulus: STARVE_MAX = 4, data requests are stores on every cycle while if_req is held.
  - Response: exactly 4 dm_gnt, then if_gnt, then starve_cnt = 0.
- Load extension:
  - Stimulus: mem_rdata = 0x12F4_80FF.
  - Response: LB @offset 2 → 0xFFFFFF80. LBU @offset 1 → 0x000000F4. LH @offset 2 → 0xFFFF80FF.
- Stores:
  - SB 0xAB @addr 0x203 → mem_be = 0001, mem_wdata = 0xABABABAB, mem_addr = 0x200.
  - SH 0x1234 @0x200 → mem_be = 1100.
- Reset mid-read:
  - Stimulus: rst_n low while in RD_DM, release, then mem_rvalid pulses.
  - Response: no dm_rvalid, all outputs 0 during reset.
- Misaligned access, macro on:
  - Stimulus: SW @0x102.
  - Response: dm_gnt and dm_err pulse, mem_req stays 0.
  - Macro off: same stimulus → mem_addr = 0x100, mem_be = 1111.
